demux_1x16_reg: RTL and testbench
=================================

Name: demux_1x16_reg

Overview:
- Registered 1-to-16 demultiplexer: the inverse of the 16x1 MUX datapath, using the same WIDTH/DEPTH/SELECT_LINE_DEPTH geometry.
- Steers one 32-bit input word to one of 16 output channels, or to all 16 when broadcast is requested.
- Each output channel has a one-entry holding register with a valid/ready handshake.
- Sits on the distribution side of the MUX test system; its outputs can feed a MUX under test for loopback checks.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 16, number of output channels; must equal 2**SELECT_LINE_DEPTH (elaboration-time check, fatal otherwise).
- SELECT_LINE_DEPTH, 4, select width.
- CNT_WIDTH, 16, width of each per-channel load counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- din  in  WIDTH  input data word.
- sel  in  SELECT_LINE_DEPTH  destination channel index.
- bcast  in  1  1 = load all channels; sel is ignored.
- in_valid  in  1  input word present.
- in_ready  out  1  demux can accept this cycle (combinational).
- dout  out  WIDTH x DEPTH (unpacked)  per-channel held data.
- out_valid  out  DEPTH  per-channel data-valid flags.
- out_ready  in  DEPTH  per-channel consumer ready.
- load_cnt  out  CNT_WIDTH x DEPTH (unpacked)  per-channel count of accepted loads.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid, every dout and every load_cnt clear to 0.
  - in_ready is forced to 0 while rst=0.
  - Pending data is discarded when reset hits mid-operation; the first accept is possible in the first cycle after rst rises.
- free[k] = !out_valid[k] || out_ready[k]. A channel that is draining this cycle counts as free, giving full throughput.
- in_ready:
  - bcast=0: in_ready = rst && free[sel].
  - bcast=1: in_ready = rst && AND over all k of free[k]. Broadcast is all-or-nothing; there are no partial loads.
- Accept = in_valid && in_ready at a rising edge.
  - Targeted channel(s) load din.
  - out_valid[k]=1 from the next cycle. Latency is 1 cycle from accept to out_valid.
- Output transfer on channel k = out_valid[k] && out_ready[k] at a rising edge.
  - Drain only: out_valid[k] goes to 0.
  - Drain and reload in the same edge: out_valid[k] stays 1 and dout[k] takes the new word.
- dout[k] is not cleared on drain; it holds its last value until the next load or reset.
- load_cnt[k] increments by 1 on every accept that loads channel k, broadcast included.
  - Wraps modulo 2**CNT_WIDTH, so 0xFFFF+1 gives 0x0000.
  - It does not count drains.
- Input protocol:
  - While in_valid=1 and in_ready=0, din, sel and bcast must stay stable and in_valid must not drop.
  - The bench asserts this; the RTL does not check it.
- out_ready is ignored on a channel whose out_valid=0.
- Channels are independent: a stalled channel never blocks a targeted load to another channel.
- No FSM beyond the per-channel full/empty state; behaviour is fully defined by the rules above.

Decomposition:
- Package demux_pkg holds:
  - WIDTH_DEF, DEPTH_DEF, SEL_W_DEF, CNT_W_DEF constants.
  - typedef data_t (logic [WIDTH-1:0]), sel_t, cnt_t.
- Sub-module demux_out_slot: one channel's holding register, valid flag, load counter and free output. Generated DEPTH times.
- The top level holds decode, the broadcast AND-reduce and in_ready.

Test Plan:
- Reset then single load: rst low 3 cycles, release; din=0xDEADBEEF, sel=5, in_valid 1 cycle, out_ready=0 -> out_valid=0x0020 next cycle, dout[5]=0xDEADBEEF, load_cnt[5]=1, all others 0.
- Backpressure: channel 5 full, out_ready[5]=0, sel=5, din=0x12345678 -> in_ready=0 and dout[5] unchanged. Raise out_ready[5] -> accept that edge, dout[5]=0x12345678, out_valid[5] stays 1, load_cnt[5]=2.
- Independence: channel 5 stalled, sel=9, din=0xA5A5A5A5 -> in_ready=1, out_valid[9]=1 next cycle; channel 5 unaffected.
- Broadcast: all empty, bcast=1, din=0x0000CAFE -> all 16 out_valid=1, every dout=0x0000CAFE, every load_cnt incremented. Repeat with channel 3 full and stalled -> in_ready=0, no channel loads.
- Streaming: sel=0, out_ready[0]=1, 100 back-to-back words 0..99 -> in_ready=1 every cycle, dout[0] sequence 0..99 with 1-cycle latency. Force load_cnt[0] to 0xFFFF, one more load -> 0x0000.
- Reset mid-operation: channels 2, 7 and 15 valid; assert rst asynchronously between edges -> out_valid, dout and load_cnt all 0 immediately. in_ready=0 until release.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared geometry and word types for the registered 1-to-16 demultiplexer.
package demux_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 16;
  localparam int SEL_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef logic [WIDTH_DEF-1:0] data_t;
  typedef logic [SEL_W_DEF-1:0] sel_t;
  typedef logic [CNT_W_DEF-1:0] cnt_t;
endpackage

// File: rtl/demux_1x16_reg_if.sv
// Input handshake plus per-channel output bus of the demultiplexer.
interface demux_1x16_reg_if #(
    parameter int WIDTH             = demux_pkg::WIDTH_DEF,
    parameter int DEPTH             = demux_pkg::DEPTH_DEF,
    parameter int SELECT_LINE_DEPTH = demux_pkg::SEL_W_DEF,
    parameter int CNT_WIDTH         = demux_pkg::CNT_W_DEF
);
    logic [WIDTH-1:0]             din;
    logic [SELECT_LINE_DEPTH-1:0] sel;
    logic                         bcast;
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             dout [DEPTH];
    logic [DEPTH-1:0]             out_valid;
    logic [DEPTH-1:0]             out_ready;
    logic [CNT_WIDTH-1:0]         load_cnt [DEPTH];

    modport master (
        output din, sel, bcast, in_valid, out_ready,
        input  in_ready, dout, out_valid, load_cnt
    );

    modport slave (
        input  din, sel, bcast, in_valid, out_ready,
        output in_ready, dout, out_valid, load_cnt
    );
endinterface

// File: rtl/demux_out_slot.sv
// One output channel: single-entry holding register, valid flag and load counter.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     din,
    input  logic                 rdy,
    output logic [WIDTH-1:0]     dout,
    output logic                 vld,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 free
);
    logic [WIDTH-1:0]     dout_q;
    logic                 vld_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    // A draining slot can take a new word on the same edge.
    assign free = !vld_q || rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (load) begin
            dout_q <= din;
            vld_q  <= 1'b1;
            cnt_q  <= cnt_q + 1'b1;
        end else if (vld_q && rdy) begin
            vld_q  <= 1'b0;
        end
    end

    assign dout = dout_q;
    assign vld  = vld_q;
    assign cnt  = cnt_q;
endmodule

// File: rtl/demux_1x16_reg.sv
// Registered 1-to-16 demux: decode, all-or-nothing broadcast and the input ready.
module demux_1x16_reg
    import demux_pkg::*;
#(
    parameter int WIDTH             = WIDTH_DEF,
    parameter int DEPTH             = DEPTH_DEF,
    parameter int SELECT_LINE_DEPTH = SEL_W_DEF,
    parameter int CNT_WIDTH         = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_1x16_reg_if.slave      bus
);
    logic [DEPTH-1:0] free;
    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] load;
    logic             tgt_free;
    logic             accept;

    if (DEPTH != 2**SELECT_LINE_DEPTH) begin : g_geom_chk
        $fatal(1, "demux_1x16_reg: DEPTH must equal 2**SELECT_LINE_DEPTH");
    end

    always_comb begin
        hit = '0;
        if (bus.bcast) hit = '1;
        else           hit[bus.sel] = 1'b1;
    end

    // Broadcast waits until every channel can take the word.
    assign tgt_free     = bus.bcast ? &free : free[bus.sel];
    assign bus.in_ready = rst && tgt_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign load         = hit & {DEPTH{accept}};

    for (genvar k = 0; k < DEPTH; k++) begin : g_ch
        demux_out_slot #(
            .WIDTH     (WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_slot (
            .clk  (clk),
            .rst  (rst),
            .load (load[k]),
            .din  (bus.din),
            .rdy  (bus.out_ready[k]),
            .dout (bus.dout[k]),
            .vld  (bus.out_valid[k]),
            .cnt  (bus.load_cnt[k]),
            .free (free[k])
        );
    end
endmodule

// File: tb/tb_demux_1x16_reg.sv
// Self-checking bench for demux_1x16_reg against a per-channel behavioural model.
module tb_demux_1x16_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    demux_1x16_reg_if bus ();
    demux_1x16_reg dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: one record per channel, updated from the rules directly.
    bit          m_vld  [16];
    logic [31:0] m_dout [16];
    logic [15:0] m_cnt  [16];
    bit          m_stall;

    function automatic bit m_ready();
        bit all_free;
        if (!rst) return 1'b0;
        all_free = 1'b1;
        for (int k = 0; k < 16; k++)
            if (m_vld[k] && !bus.out_ready[k]) all_free = 1'b0;
        if (bus.bcast) return all_free;
        return !m_vld[bus.sel] || bus.out_ready[bus.sel];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 16; k++) begin
                m_vld[k] = 1'b0; m_dout[k] = '0; m_cnt[k] = '0;
            end
            m_stall = 1'b0;
        end else begin
            bit acc;
            acc = bus.in_valid && m_ready();
            for (int k = 0; k < 16; k++) begin
                if (acc && (bus.bcast || bus.sel == k)) begin
                    m_vld[k] = 1'b1; m_dout[k] = bus.din; m_cnt[k] = m_cnt[k] + 16'd1;
                end else if (m_vld[k] && bus.out_ready[k]) begin
                    m_vld[k] = 1'b0;
                end
            end
            m_stall = bus.in_valid && !acc;
        end
    end

    property p_hold;
        @(posedge clk) disable iff (!rst)
        (bus.in_valid && !bus.in_ready) |=>
            (bus.in_valid && $stable(bus.din) && $stable(bus.sel) && $stable(bus.bcast));
    endproperty
    a_hold: assert property (p_hold);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        bus.din = '0; bus.sel = '0; bus.bcast = 1'b0; bus.in_valid = 1'b1; bus.out_ready = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.out_valid[k] !== 1'b0 || bus.dout[k] !== 32'h0 || bus.load_cnt[k] !== 16'h0) begin
                errors++;
                $display("FAIL reset_ch%0d: got v=%b d=%h c=%h want all zero",
                         k, bus.out_valid[k], bus.dout[k], bus.load_cnt[k]);
            end
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_single_load();
        @(negedge clk);
        bus.din = 32'hDEADBEEF; bus.sel = 4'd5; bus.in_valid = 1'b1;
        #1 checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 checks++;
        if (bus.out_valid !== 16'h0020 || bus.dout[5] !== 32'hDEADBEEF || bus.load_cnt[5] !== 16'd1) begin
            errors++;
            $display("FAIL single_load: got v=%h d5=%h c5=%0d want v=0020 d5=deadbeef c5=1",
                     bus.out_valid, bus.dout[5], bus.load_cnt[5]);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.out_valid[k] !== m_vld[k] || bus.dout[k] !== m_dout[k] || bus.load_cnt[k] !== m_cnt[k]) begin
                errors++;
                $display("FAIL single_ch%0d: got v=%b d=%h c=%h want v=%b d=%h c=%h", k,
                         bus.out_valid[k], bus.dout[k], bus.load_cnt[k], m_vld[k], m_dout[k], m_cnt[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.din = 32'h12345678; bus.sel = 4'd5; bus.in_valid = 1'b1; bus.out_ready = '0;
        #1 checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready_stalled: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.dout[5] !== 32'hDEADBEEF || bus.load_cnt[5] !== 16'd1) begin
            errors++; $display("FAIL bp_hold: got d5=%h c5=%0d want deadbeef 1", bus.dout[5], bus.load_cnt[5]);
        end
        bus.out_ready[5] = 1'b1;
        #1 checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_in_ready_drain: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = '0;
        #1 checks++;
        if (bus.dout[5] !== 32'h12345678 || bus.out_valid[5] !== 1'b1 || bus.load_cnt[5] !== 16'd2) begin
            errors++;
            $display("FAIL bp_reload: got d5=%h v5=%b c5=%0d want 12345678 1 2",
                     bus.dout[5], bus.out_valid[5], bus.load_cnt[5]);
        end
    endtask

    task automatic test_independence();
        bus.din = 32'hA5A5A5A5; bus.sel = 4'd9; bus.in_valid = 1'b1;
        #1 checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL indep_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 checks++;
        if (bus.out_valid !== 16'h0220 || bus.dout[9] !== 32'hA5A5A5A5 || bus.dout[5] !== 32'h12345678) begin
            errors++;
            $display("FAIL indep: got v=%h d9=%h d5=%h want 0220 a5a5a5a5 12345678",
                     bus.out_valid, bus.dout[9], bus.dout[5]);
        end
    endtask

    task automatic test_broadcast();
        bus.out_ready = '1;
        @(negedge clk);
        bus.out_ready = '0;
        bus.din = 32'h0000CAFE; bus.bcast = 1'b1; bus.in_valid = 1'b1;
        #1 checks++;
        if (bus.out_valid !== 16'h0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bc_empty: got v=%h rdy=%b want 0000 1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.out_valid[k] !== 1'b1 || bus.dout[k] !== 32'h0000CAFE || bus.load_cnt[k] !== m_cnt[k]) begin
                errors++;
                $display("FAIL bc_ch%0d: got v=%b d=%h c=%h want 1 0000cafe %h",
                         k, bus.out_valid[k], bus.dout[k], bus.load_cnt[k], m_cnt[k]);
            end
        end
        // Drain everything except channel 3, then broadcast into the stall.
        bus.out_ready = 16'hFFF7;
        @(negedge clk);
        bus.out_ready = '0;
        bus.din = 32'hBEEF0000; bus.in_valid = 1'b1;
        #1 checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bc_stall_rdy: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 16'h0008 || bus.dout[0] !== 32'h0000CAFE || bus.dout[3] !== 32'h0000CAFE) begin
            errors++;
            $display("FAIL bc_no_partial: got v=%h d0=%h d3=%h want 0008 0000cafe 0000cafe",
                     bus.out_valid, bus.dout[0], bus.dout[3]);
        end
        bus.out_ready[3] = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.bcast = 1'b0; bus.out_ready = '0;
        #1 for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.out_valid[k] !== m_vld[k] || bus.dout[k] !== 32'hBEEF0000 || bus.load_cnt[k] !== m_cnt[k]) begin
                errors++;
                $display("FAIL bc2_ch%0d: got v=%b d=%h c=%h want %b beef0000 %h",
                         k, bus.out_valid[k], bus.dout[k], bus.load_cnt[k], m_vld[k], m_cnt[k]);
            end
        end
    endtask

    task automatic test_streaming();
        bus.sel = 4'd0; bus.bcast = 1'b0; bus.out_ready = 16'h0001;
        for (int i = 0; i < 100; i++) begin
            bus.din = i; bus.in_valid = 1'b1;
            #1 checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_rdy[%0d]: got %b want 1", i, bus.in_ready);
            end
            @(negedge clk);
            checks++;
            if (bus.dout[0] !== i || bus.out_valid[0] !== 1'b1) begin
                errors++; $display("FAIL stream_dout[%0d]: got %0d v=%b want %0d 1", i, bus.dout[0], bus.out_valid[0], i);
            end
        end
        bus.in_valid = 1'b0;
        force dut.g_ch[0].u_slot.cnt_q = 16'hFFFF;
        #1 release dut.g_ch[0].u_slot.cnt_q;
        m_cnt[0] = 16'hFFFF;
        bus.din = 32'h0000_0BAD; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = '0;
        #1 checks++;
        if (bus.load_cnt[0] !== 16'h0000 || bus.dout[0] !== 32'h0000_0BAD) begin
            errors++; $display("FAIL cnt_wrap: got c0=%h d0=%h want 0000 00000bad", bus.load_cnt[0], bus.dout[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            if (!m_stall) begin
                bus.din = $urandom; bus.sel = 4'($urandom_range(0, 15));
                bus.bcast = ($urandom_range(0, 9) == 0); bus.in_valid = $urandom_range(0, 1);
            end
            bus.out_ready = 16'($urandom);
            #1 checks++;
            if (bus.in_ready !== m_ready()) begin
                errors++; $display("FAIL rand_rdy[%0d]: got %b want %b", n, bus.in_ready, m_ready());
            end
            @(negedge clk);
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (bus.out_valid[k] !== m_vld[k] || bus.dout[k] !== m_dout[k] || bus.load_cnt[k] !== m_cnt[k]) begin
                    errors++;
                    $display("FAIL rand[%0d]_ch%0d: got v=%b d=%h c=%h want v=%b d=%h c=%h", n, k,
                             bus.out_valid[k], bus.dout[k], bus.load_cnt[k], m_vld[k], m_dout[k], m_cnt[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b0; bus.bcast = 1'b0; bus.out_ready = '1;
        @(negedge clk);
        bus.out_ready = '0;
        foreach (bus.dout[k]) if (k == 2 || k == 7 || k == 15) begin
            bus.sel = 4'(k); bus.din = 32'h100 + k; bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1 checks++;
        if (bus.out_valid !== 16'h8084) begin
            errors++; $display("FAIL mid_setup: got v=%h want 8084", bus.out_valid);
        end
        bus.sel = 4'd0; bus.in_valid = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 checks++;
        if (bus.out_valid !== 16'h0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got v=%h rdy=%b want 0000 0", bus.out_valid, bus.in_ready);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.dout[k] !== 32'h0 || bus.load_cnt[k] !== 16'h0) begin
                errors++; $display("FAIL mid_ch%0d: got d=%h c=%h want 0 0", k, bus.dout[k], bus.load_cnt[k]);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 16'h0) begin
            errors++; $display("FAIL mid_held: got rdy=%b v=%h want 0 0000", bus.in_ready, bus.out_valid);
        end
        rst = 1'b1; bus.din = 32'h0000_5EED;
        #1 checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_release_rdy: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 checks++;
        if (bus.out_valid !== 16'h0001 || bus.dout[0] !== 32'h0000_5EED || bus.load_cnt[0] !== 16'd1) begin
            errors++;
            $display("FAIL mid_first_accept: got v=%h d0=%h c0=%0d want 0001 00005eed 1",
                     bus.out_valid, bus.dout[0], bus.load_cnt[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_backpressure();
        test_independence();
        test_broadcast();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
